// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared opcode and FSM state encodings for ram_arbiter
package ram_arb_pkg;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        OWN     = 2'b01,
        WAIT_RD = 2'b10
    } state_e;

    // Requester 1 counts as last served out of reset so requester 0 wins first.
    localparam logic RESET_LAST_SERVED = 1'b1;

    function automatic opcode_e cmd_opcode(input logic [1:0] op_bits);
        return opcode_e'(op_bits);
    endfunction

endpackage

// File: rtl/ram_arb_timer.sv
// rtl/ram_arb_timer.sv - lock-hold counter; expire flags the LIMIT-th stalled cycle
module ram_arb_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic clear,
    output logic expire
);

    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    // The cycle being counted is the LIMIT-th one when cnt already holds LIMIT-1.
    assign expire = active && !clear && (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || !active || clear || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester round-robin RAM command arbiter; RAM_ARB_TIMEOUT_EN enables forced lock release
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_SIZE      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE+1:0] req0_data,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    output logic [ADDR_SIZE-1:0] req0_rdata,
    output logic                 req0_rvalid,
    input  logic [ADDR_SIZE+1:0] req1_data,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    output logic [ADDR_SIZE-1:0] req1_rdata,
    output logic                 req1_rvalid,
    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    input  logic                 ram_tx_valid,
    output logic                 owner,
    output logic                 busy,
    output logic                 timeout
);

    localparam int CMD_W = ADDR_SIZE + 2;

    state_e             state, state_next;
    logic               owner_q;
    logic               last_served;
    logic               any_valid;
    logic               grant;
    logic               cur_valid;
    logic [CMD_W-1:0]   cur_data;
    opcode_e            cur_op;
    logic               accept;
    logic               rd_done;
    logic               expire;
    logic               release_lock;
    logic               timeout_q;

    assign any_valid = req0_valid || req1_valid;
    // On contention, grant the requester that was not served last.
    assign grant     = (req0_valid && req1_valid) ? ~last_served : req1_valid;

    assign cur_valid = owner_q ? req1_valid : req0_valid;
    assign cur_data  = owner_q ? req1_data  : req0_data;
    assign cur_op    = cmd_opcode(cur_data[CMD_W-1 -: 2]);

    assign req0_ready = (state == OWN) && !owner_q;
    assign req1_ready = (state == OWN) &&  owner_q;
    assign accept     = (state == OWN) && cur_valid;
    assign rd_done    = (state == WAIT_RD) && ram_tx_valid;

    assign owner   = owner_q;
    assign busy    = (state != IDLE);
    assign timeout = timeout_q;

`ifdef RAM_ARB_TIMEOUT_EN
    ram_arb_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .active (state != IDLE),
        .clear  (accept || rd_done),
        .expire (expire)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        release_lock = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    state_next = OWN;
                end
            end
            OWN: begin
                if (accept) begin
                    if (cur_op == OP_WR_DATA) begin
                        state_next   = IDLE;
                        release_lock = 1'b1;
                    end else if (cur_op == OP_RD_DATA) begin
                        state_next = WAIT_RD;
                    end
                end else if (expire) begin
                    state_next   = IDLE;
                    release_lock = 1'b1;
                end
            end
            WAIT_RD: begin
                if (rd_done || expire) begin
                    state_next   = IDLE;
                    release_lock = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= 1'b0;
            last_served  <= RESET_LAST_SERVED;
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
            req0_rdata   <= '0;
            req0_rvalid  <= 1'b0;
            req1_rdata   <= '0;
            req1_rvalid  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            ram_rx_valid <= accept;
            if (accept) begin
                ram_din <= cur_data;
            end
            if (state == IDLE && any_valid) begin
                owner_q <= grant;
            end
            if (release_lock) begin
                last_served <= owner_q;
            end
            req0_rvalid <= rd_done && !owner_q;
            req1_rvalid <= rd_done &&  owner_q;
            if (rd_done && !owner_q) begin
                req0_rdata <= ram_dout;
            end
            if (rd_done && owner_q) begin
                req1_rdata <= ram_dout;
            end
            timeout_q <= expire;
        end
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 8: RAM address/data width; command words are ADDR_SIZE+2 bits.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: lock-timeout limit; used only with RAM_ARB_TIMEOUT_EN.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0_data  input  ADDR_SIZE+2  requester-0 command word; bits [ADDR_SIZE+1:ADDR_SIZE] are the opcode.
REQ-006 req0_valid  input  1  requester-0 word valid.
REQ-007 req0_ready  output  1  requester-0 word accepted when valid and ready are both high.
REQ-008 req0_rdata  output  ADDR_SIZE  read data returned to requester 0.
REQ-009 req0_rvalid  output  1  one-cycle strobe qualifying req0_rdata.
REQ-010 req1_data, req1_valid, req1_ready, req1_rdata, req1_rvalid: same directions, widths and meanings as REQ-005 to REQ-009, for requester 1.
REQ-011 ram_din  output  ADDR_SIZE+2  command word forwarded to the RAM.
REQ-012 ram_rx_valid  output  1  one-cycle strobe qualifying ram_din.
REQ-013 ram_dout  input  ADDR_SIZE  RAM read data.
REQ-014 ram_tx_valid  input  1  RAM read-data strobe.
REQ-015 owner  output  1  index of the current lock holder.
REQ-016 busy  output  1  high whenever the state is not IDLE.
REQ-017 timeout  output  1  one-cycle strobe on a forced lock release.

Function
REQ-018 Opcodes SHALL be decoded as follows: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
REQ-019 FSM states SHALL be IDLE, OWN and WAIT_RD.
REQ-020 In IDLE, any valid request SHALL set owner and move to OWN on the next cycle; no word is accepted while in IDLE.
REQ-021 Arbitration SHALL be round-robin: when both requesters are valid, the grant goes to the requester not served last; after reset, requester 0 wins.
REQ-022 reqN_ready SHALL equal (state==OWN && owner==N), combinationally; the non-owner's ready SHALL stay low.
REQ-023 On each accepted word, ram_din SHALL register the word and ram_rx_valid SHALL pulse for exactly one cycle, starting the following cycle (latency 1).
REQ-024 Accepting WR_ADDR or RD_ADDR SHALL keep the state in OWN, locking the grant so the other requester cannot interleave.
REQ-025 Accepting WR_DATA SHALL forward the word, move to IDLE and record the owner as last served.
REQ-026 Accepting RD_DATA SHALL forward the word and move to WAIT_RD.
REQ-027 A data opcode accepted without a preceding address word SHALL still be forwarded and SHALL end the transaction as in REQ-025 and REQ-026.
REQ-028 In WAIT_RD, both ready outputs SHALL be low; on ram_tx_valid, reqN_rdata SHALL register ram_dout for the owner, reqN_rvalid SHALL pulse for one cycle, and the state SHALL move to IDLE.
REQ-029 ram_tx_valid SHALL be ignored outside WAIT_RD.
REQ-030 The non-owner's rdata SHALL hold its last value, and its rvalid SHALL stay 0.

Reset
REQ-031 While rst is high, the state SHALL be IDLE, and all of the following SHALL be 0: owner, busy, timeout, both ready, both rvalid, both rdata, ram_din, ram_rx_valid.
REQ-032 Reset asserted mid-transaction SHALL abandon the lock, with no ram_rx_valid pulse issued afterwards.
REQ-033 Reset SHALL set last served to requester 1, so that requester 0 wins the first arbitration.

Configuration
REQ-034 With RAM_ARB_TIMEOUT_EN defined, a counter SHALL count consecutive cycles spent in OWN without a handshake, and cycles spent in WAIT_RD.
REQ-035 With RAM_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the FSM SHALL go to IDLE, timeout SHALL pulse for one cycle, and the owner SHALL be recorded as last served.
REQ-036 With RAM_ARB_TIMEOUT_EN undefined, there SHALL be no counter, timeout SHALL be tied to 0, and a lock SHALL be held indefinitely.

Structure
REQ-037 The shared package ram_arb_pkg SHALL hold the opcode constants and the FSM state encoding.
REQ-038 The timeout counter SHALL be the sub-module ram_arb_timer, instantiated only under RAM_ARB_TIMEOUT_EN.

Verification
REQ-039 Write sequence: req0 sends 0x0AA then 0x155 -> ram_din 0x0AA then 0x155, each with one ram_rx_valid pulse; state returns to IDLE.
REQ-040 Read sequence: req1 sends 0x212 then 0x300; RAM returns 0x5C -> req1_rdata=0x5C with one req1_rvalid pulse; req0_rvalid stays 0.
REQ-041 Both requesters valid from reset -> req0 granted first; after its WR_DATA, req1 granted next.
REQ-042 Lock test: req0 sends WR_ADDR, then req1 raises valid -> req1_ready stays 0 until req0's WR_DATA is accepted.
REQ-043 Reset mid-transaction: rst asserted in WAIT_RD, then ram_tx_valid -> no rvalid pulse; all outputs 0.
REQ-044 Timeout (macro on, TIMEOUT_CYCLES=4): req0 sends WR_ADDR, then stalls -> timeout pulses 4 cycles later; req1 is granted next.
